ram_arbiter: RTL and testbench

Two-requester arbiter that shares the single data `ram` (word/half-word/byte, write on posedge, combinational read) between the pipeline MEM stage (master 0) and a secondary master (master 1: loader/debug/DMA). It grants at most one access per cycle with round-robin fairness. It rejects misaligned or invalid-width accesses before they reach the RAM. It returns registered read data with a one-cycle response pulse.

---
 rtl/ram_arbiter.sv | 86 ++++++++
 tb/tb_ram_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one data RAM between two masters
module ram_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wena,
    input  logic [1:0]  m0_width,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_wena,
    input  logic [1:0]  m1_width,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        ram_wena,
    output logic [1:0]  ram_width,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out
);
    logic        last;
    logic        sel;
    logic        any;
    logic        wena;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bad;
    logic [31:0] rdata_next;

    // Under contention the master that was not granted last time wins.
    assign m0_gnt = m0_req & (~m1_req | last);
    assign m1_gnt = m1_req & (~m0_req | ~last);

    // Mux the granted master onto the RAM and classify the access.
    always_comb begin
        sel         = m1_gnt;
        any         = m0_gnt | m1_gnt;
        wena        = sel ? m1_wena : m0_wena;
        width       = sel ? m1_width : m0_width;
        addr        = sel ? m1_addr : m0_addr;
        wdata       = sel ? m1_wdata : m0_wdata;
        bad         = (width == 2'd3) | ((width == 2'd0) & (addr[1:0] != 2'd0)) |
                      ((width == 2'd1) & addr[0]) | (addr >= ADDR_LIMIT);
        ram_wena    = any & wena & ~bad & ~rst;
        ram_width   = any ? width : 2'd0;
        ram_addr    = any ? addr : 32'd0;
        ram_data_in = any ? wdata : 32'd0;
        rdata_next  = (wena | bad) ? 32'd0 : ram_data_out;
    end

    // Arbitration history and per-master registered responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 1'b1;
            m0_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rvalid <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= 32'd0;
        end else begin
            m0_rvalid <= m0_gnt;
            m1_rvalid <= m1_gnt;
            if (any) last <= sel;
            if (m0_gnt) begin
                m0_err   <= bad;
                m0_rdata <= rdata_next;
            end
            if (m1_gnt) begin
                m1_err   <= bad;
                m1_rdata <= rdata_next;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a byte-lane RAM model
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_wena = 0, m1_req = 0, m1_wena = 0;
    logic [1:0]  m0_width = 0, m1_width = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_wena;
    logic [1:0]  ram_width;
    logic [31:0] ram_addr, ram_data_in, ram_data_out;
    logic [31:0] mem [0:4095];
    logic [31:0] rword;
    int checks = 0;
    int failures = 0;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wena(m0_wena), .m0_width(m0_width), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wena(m1_wena), .m1_width(m1_width), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_wena(ram_wena), .ram_width(ram_width), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // RAM model: lane placement on write, zero-extended combinational read.
    always @(posedge clk) begin
        if (ram_wena) begin
            if (ram_width == 2'd0) mem[ram_addr[13:2]] <= ram_data_in;
            else if (ram_width == 2'd1) mem[ram_addr[13:2]][{ram_addr[1], 4'b0000} +: 16] <= ram_data_in[15:0];
            else mem[ram_addr[13:2]][{ram_addr[1:0], 3'b000} +: 8] <= ram_data_in[7:0];
        end
    end

    always_comb begin
        rword = mem[ram_addr[13:2]] >> {ram_addr[1:0], 3'b000};
        ram_data_out = (ram_width == 2'd0) ? mem[ram_addr[13:2]] :
                       (ram_width == 2'd1) ? {16'd0, rword[15:0]} : {24'd0, rword[7:0]};
    end

    task automatic set_m0(input logic req, input logic we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        m0_req = req; m0_wena = we; m0_width = w; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        m1_req = req; m1_wena = we; m1_width = w; m1_addr = a; m1_wdata = d;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", m0_rvalid, m1_rvalid); end
        checks++; if (m0_err !== 1'b0 || m1_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", m0_err, m1_err); end
        checks++; if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", m0_rdata, m1_rdata); end
        checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || ram_wena !== 1'b0 || ram_width !== 2'd0 || ram_addr !== 32'd0 || ram_data_in !== 32'd0) begin
            failures++; $display("FAIL idle_ram got=gnt%b%b we%b w%0d a%h d%h exp=all0", m0_gnt, m1_gnt, ram_wena, ram_width, ram_addr, ram_data_in); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1; #1; rst = 1'b0;
    endtask

    task automatic test_m0_rw;
        set_m0(1, 1, 2'd0, 32'h10, 32'hDEADBEEF);
        #1;
        checks++; if (m0_gnt !== 1'b1 || ram_wena !== 1'b1 || ram_addr !== 32'h10 || ram_data_in !== 32'hDEADBEEF) begin
            failures++; $display("FAIL m0_wr_gnt got=gnt%b we%b a%h d%h exp=gnt1 we1 a10 dDEADBEEF", m0_gnt, ram_wena, ram_addr, ram_data_in); end
        @(posedge clk); #1;
        checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'd0) begin
            failures++; $display("FAIL m0_wr_resp got=v%b e%b d%h exp=v1 e0 d0", m0_rvalid, m0_err, m0_rdata); end
        m0_wena = 0;
        #1;
        checks++; if (m0_gnt !== 1'b1 || ram_wena !== 1'b0) begin failures++; $display("FAIL m0_rd_gnt got=gnt%b we%b exp=gnt1 we0", m0_gnt, ram_wena); end
        @(posedge clk); #1;
        m0_req = 0;
        checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL m0_rd_resp got=v%b e%b d%h exp=v1 e0 dDEADBEEF", m0_rvalid, m0_err, m0_rdata); end
        @(posedge clk); #1;
        checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL m0_rvalid_drop got=v%b d%h exp=v0 dDEADBEEF", m0_rvalid, m0_rdata); end
    endtask

    task automatic test_contention;
        do_reset();
        set_m0(1, 0, 2'd0, 32'h0, 32'd0);
        set_m1(1, 0, 2'd0, 32'h4, 32'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1)) begin
                failures++; $display("FAIL rr_gnt%0d got=%b%b exp=%b%b", i, m0_gnt, m1_gnt, i % 2 == 0, i % 2 == 1); end
            @(posedge clk); #1;
            if (i % 2 == 0) begin
                checks++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 32'hA5A50000) begin
                    failures++; $display("FAIL rr_resp%0d got=v%b%b d%h exp=v10 dA5A50000", i, m0_rvalid, m1_rvalid, m0_rdata); end
            end else begin
                checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b1 || m1_rdata !== 32'hA5A50001) begin
                    failures++; $display("FAIL rr_resp%0d got=v%b%b d%h exp=v01 dA5A50001", i, m0_rvalid, m1_rvalid, m1_rdata); end
            end
        end
        m0_req = 0; m1_req = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_byte;
        set_m1(1, 1, 2'd2, 32'h13, 32'h000000AB);
        #1;
        checks++; if (m1_gnt !== 1'b1 || ram_wena !== 1'b1 || ram_width !== 2'd2) begin
            failures++; $display("FAIL byte_wr_gnt got=gnt%b we%b w%0d exp=gnt1 we1 w2", m1_gnt, ram_wena, ram_width); end
        @(posedge clk); #1;
        set_m1(1, 0, 2'd0, 32'h10, 32'd0);
        @(posedge clk); #1;
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hABADBEEF || m1_err !== 1'b0) begin
            failures++; $display("FAIL byte_word_rd got=v%b e%b d%h exp=v1 e0 dABADBEEF", m1_rvalid, m1_err, m1_rdata); end
        set_m1(1, 0, 2'd2, 32'h13, 32'd0);
        @(posedge clk); #1;
        m1_req = 0;
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h000000AB) begin
            failures++; $display("FAIL byte_rd got=v%b d%h exp=v1 d000000AB", m1_rvalid, m1_rdata); end
        checks++; if (m0_rdata !== 32'hA5A50000) begin failures++; $display("FAIL m0_rdata_hold got=%h exp=A5A50000", m0_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned;
        logic [1:0]  w [4];
        logic [31:0] a [4];
        logic        we [4];
        w = '{2'd0, 2'd1, 2'd3, 2'd0};
        a = '{32'h12, 32'h11, 32'h10, 32'h4000};
        we = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            set_m0(1, we[i], w[i], a[i], 32'h12345678);
            #1;
            checks++; if (m0_gnt !== 1'b1 || ram_wena !== 1'b0) begin
                failures++; $display("FAIL bad%0d_gnt got=gnt%b we%b exp=gnt1 we0", i, m0_gnt, ram_wena); end
            @(posedge clk); #1;
            checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'd0) begin
                failures++; $display("FAIL bad%0d_resp got=v%b e%b d%h exp=v1 e1 d0", i, m0_rvalid, m0_err, m0_rdata); end
        end
        set_m0(1, 0, 2'd0, 32'h10, 32'd0);
        @(posedge clk); #1;
        m0_req = 0;
        checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hABADBEEF) begin
            failures++; $display("FAIL bad_mem_intact got=v%b e%b d%h exp=v1 e0 dABADBEEF", m0_rvalid, m0_err, m0_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid;
        set_m1(1, 0, 2'd0, 32'h10, 32'd0);
        @(posedge clk); #1;
        m1_req = 0;
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hABADBEEF) begin
            failures++; $display("FAIL rst_mid_pre got=v%b d%h exp=v1 dABADBEEF", m1_rvalid, m1_rdata); end
        #1; rst = 1'b1; #1;
        checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'd0) begin
            failures++; $display("FAIL rst_mid_drop got=v%b d%h exp=v0 d0", m1_rvalid, m1_rdata); end
        #1; rst = 1'b0;
        set_m0(1, 0, 2'd0, 32'h0, 32'd0);
        set_m1(1, 0, 2'd0, 32'h4, 32'd0);
        #1;
        checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            failures++; $display("FAIL rst_mid_first got=%b%b exp=10", m0_gnt, m1_gnt); end
        @(posedge clk); #1;
        m0_req = 0; m1_req = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_rst_write;
        rst = 1'b1;
        set_m0(1, 1, 2'd0, 32'h20, 32'hCAFEF00D);
        #1;
        checks++; if (m0_gnt !== 1'b1 || ram_wena !== 1'b0) begin
            failures++; $display("FAIL rst_wr_block got=gnt%b we%b exp=gnt1 we0", m0_gnt, ram_wena); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        m0_req = 0;
        #1; rst = 1'b0;
        set_m0(1, 0, 2'd0, 32'h20, 32'd0);
        @(posedge clk); #1;
        m0_req = 0;
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA5A50008) begin
            failures++; $display("FAIL rst_wr_prior got=v%b d%h exp=v1 dA5A50008", m0_rvalid, m0_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = {16'hA5A5, i[15:0]};
        test_reset();
        test_m0_rw();
        test_contention();
        test_byte();
        test_misaligned();
        test_rst_mid();
        test_rst_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
